// File: rtl/lcd_64_to_32_bits_dfa_splitter_pkg.sv
// Shared definitions for the 64-to-32 bit beat splitter: state encoding,
// symbol geometry and the short-beat rule.
package lcd_64_to_32_bits_dfa_splitter_pkg;

  localparam int SYMBOL_W    = 8;
  localparam int IN_SYMBOLS  = 8;
  localparam int OUT_SYMBOLS = 4;
  localparam int IN_W        = SYMBOL_W * IN_SYMBOLS;
  localparam int OUT_W       = SYMBOL_W * OUT_SYMBOLS;
  localparam int IN_EMPTY_W  = $clog2(IN_SYMBOLS);
  localparam int OUT_EMPTY_W = $clog2(OUT_SYMBOLS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2
  } state_e;

  // A final beat whose lower half is entirely unused only yields its upper half.
  function automatic logic isShortBeat(input logic eop, input logic [IN_EMPTY_W-1:0] empty);
    return eop && (empty >= IN_EMPTY_W'(OUT_SYMBOLS));
  endfunction

endpackage

// File: rtl/lcd_64_to_32_bits_dfa_splitter.sv
// Splits each 64-bit streaming beat into two 32-bit beats (upper half first),
// dropping the lower half of a final beat that holds four or fewer symbols.
module lcd_64_to_32_bits_dfa_splitter
  import lcd_64_to_32_bits_dfa_splitter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [IN_EMPTY_W-1:0]  in_empty,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [OUT_EMPTY_W-1:0] out_empty
);

  state_e                 state_q, state_d;
  logic [IN_W-1:0]        hold_q;
  logic                   sop_q, eop_q;
  logic [IN_EMPTY_W-1:0]  empty_q;
  logic                   shortBeat;
  logic                   inAccept;

  assign shortBeat = isShortBeat(eop_q, empty_q);

  assign in_ready = (state_q == ST_EMPTY)
                 || (state_q == ST_LOW  && out_ready)
                 || (state_q == ST_HIGH && out_ready && shortBeat);

  assign inAccept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else begin
      state_q <= state_d;
      if (inAccept) begin
        sop_q   <= in_startofpacket;
        eop_q   <= in_endofpacket;
        empty_q <= in_endofpacket ? in_empty : '0;
      end
    end
  end

  // Payload is left uncleared by reset; state alone decides whether it is visible.
  always_ff @(posedge clk) begin
    if (inAccept) begin
      hold_q <= in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (inAccept) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (out_ready) begin
          if (!shortBeat)    state_d = ST_LOW;
          else if (inAccept) state_d = ST_HIGH;
          else               state_d = ST_EMPTY;
        end
      end
      ST_LOW: begin
        if (out_ready) state_d = inAccept ? ST_HIGH : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid         = 1'b0;
    out_data          = hold_q[IN_W-1:OUT_W];
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    unique case (state_q)
      ST_HIGH: begin
        out_valid         = 1'b1;
        out_data          = hold_q[IN_W-1:OUT_W];
        out_startofpacket = sop_q;
        out_endofpacket   = shortBeat;
        // empty is 4..7 when short, so its low bits equal empty-4.
        out_empty         = shortBeat ? empty_q[OUT_EMPTY_W-1:0] : '0;
      end
      ST_LOW: begin
        out_valid         = 1'b1;
        out_data          = hold_q[OUT_W-1:0];
        out_endofpacket   = eop_q;
        out_empty         = eop_q ? empty_q[OUT_EMPTY_W-1:0] : '0;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/lcd_64_to_32_bits_dfa_splitter.md
LCD_64_TO_32_BITS_DFA_SPLITTER -- requirements
Module: lcd_64_to_32_bits_dfa_splitter

Interface
REQ-001 Parameter: none; beat width fixed at 64 bits in, 32 bits out, 8-bit symbols, big-endian (first symbol in MSBs).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 in_data  input  64  sink beat, 8 symbols, symbol 0 in [63:56].
REQ-005 in_valid  input  1  sink beat valid.
REQ-006 in_ready  output  1  sink may transfer; beat accepted when in_valid && in_ready at rising clk.
REQ-007 in_startofpacket  input  1  first beat of packet.
REQ-008 in_endofpacket  input  1  last beat of packet.
REQ-009 in_empty  input  3  unused symbols in last beat, counted from LSB end; meaningful only with in_endofpacket.
REQ-010 out_data  output  32  source half-beat, symbol 0 in [31:24].
REQ-011 out_valid  output  1  source beat valid.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-013 out_startofpacket  output  1  first output beat of packet.
REQ-014 out_endofpacket  output  1  last output beat of packet.
REQ-015 out_empty  output  2  unused symbols in last output beat.

Function
REQ-016 FSM states: EMPTY (nothing held), HIGH (presenting in_data[63:32]), LOW (presenting in_data[31:0]).
REQ-017 Accepted beat captured into 64-bit hold register plus sop/eop/empty flags; out_valid asserts the cycle after acceptance (latency 1).
REQ-018 in_ready = (state==EMPTY) || (state==LOW && out_ready) || (state==HIGH && out_ready && short_beat), combinational from state and out_ready only, never from in_valid.
REQ-019 short_beat = held eop && held empty>=4; only the upper half is emitted.
REQ-020 EMPTY -> HIGH on acceptance; HIGH -> LOW on out transfer when !short_beat; HIGH (short_beat) and LOW: on out transfer go HIGH if a new beat is accepted same cycle, else EMPTY.
REQ-021 out_valid = (state!=EMPTY); out_data = hold[63:32] in HIGH, hold[31:0] in LOW.
REQ-022 out_startofpacket = held sop in HIGH, 0 in LOW.
REQ-023 HIGH: out_endofpacket = short_beat; out_empty = short_beat ? held empty-4 : 0.
REQ-024 LOW: out_endofpacket = held eop; out_empty = held eop ? held empty[1:0] : 0.
REQ-025 in_empty ignored (treated as 0) when in_endofpacket=0.
REQ-026 While out_valid && !out_ready, all out_* signals held stable and state unchanged.
REQ-027 Full throughput: back-to-back full beats with out_ready=1 produce one 32-bit transfer every cycle, in_ready asserted every second cycle.
REQ-028 No packet-framing checking; sop/eop passed through as received.

Reset
REQ-029 On reset: state=EMPTY, out_valid=0, in_ready=1 (combinational), out_startofpacket=0, out_endofpacket=0, out_empty=0; hold register data not cleared.
REQ-030 Reset mid-packet discards held beat; no partial output after reset release.
REQ-031 First beat may be accepted the cycle after reset deasserts.

Structure
REQ-032 Shared package: state encoding (EMPTY/HIGH/LOW), symbol width 8, in/out symbols-per-beat 8/4.
REQ-033 No sub-module; single FSM plus hold register in one module.

Verification
REQ-034 Single beat 0x0011223344556677, sop=eop=1, empty=0, out_ready=1 -> 0x00112233 (sop=1,eop=0,empty=0) then 0x44556677 (sop=0,eop=1,empty=0).
REQ-035 Beat 0xAABBCCDD_EEFF0011, sop=eop=1, empty=5 -> single output 0xAABBCCDD, sop=1, eop=1, empty=1; in_ready high the following cycle.
REQ-036 Three-beat packet, out_ready=1, in_valid continuous -> six consecutive out transfers, no bubbles, in_ready pattern 1,0,1,0,1,0.
REQ-037 out_ready=0 for 5 cycles while in HIGH -> out_data/sop/eop/empty unchanged, in_ready=0 throughout; resumes correct order on release.
REQ-038 reset asserted one cycle while in LOW -> next cycle out_valid=0, in_ready=1; following packet emitted correctly.
REQ-039 eop=0 with in_empty=6 -> both halves emitted, out_empty=0, out_endofpacket=0.
